fifo_drain: RTL and testbench
=============================

// Module: fifo_drain
// PURPOSE
//  Read-side master for the 8-bit, 16-deep synchronous FIFO (ports clk/rst/we/re/di/dout/full/empty).
//  - Pops bytes whenever the FIFO is non-empty, absorbing the FIFO's 1-cycle read latency in a small skid buffer.
//  - Presents the bytes on a valid/ready stream toward downstream logic (UART TX, packetiser).
// PARAMETERS
//  DATA_W      8  byte width; must match the FIFO.
//  SKID_DEPTH  3  skid-buffer entries; minimum 2; >=3 needed for 1 byte/cycle.
// PORTS
//  clk      in   1       system clock; all logic on posedge.
//  rst      in   1       synchronous, active-high reset.
//  en       in   1       1 = drain FIFO; 0 = stop issuing reads.
//  empty    in   1       FIFO empty flag.
//  dout     in   DATA_W  FIFO read data; valid the cycle after re=1.
//  re       out  1       FIFO read enable.
//  m_valid  out  1       stream byte valid.
//  m_data   out  DATA_W  stream byte.
//  m_ready  in   1       downstream accepts when m_valid&m_ready.
//  busy     out  1       state != IDLE.
//  csum     out  DATA_W  (FIFO_DRAIN_SUM_EN only) running checksum.
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; occ=0; inflight=0; rd/wr ptr=0; m_data=0; csum=0.
//   - Outputs therefore read re=0, m_valid=0, busy=0.
//  FSM (registered):
//   - IDLE -> ACTIVE when en=1.
//   - ACTIVE -> DRAIN when en=0.
//   - DRAIN -> IDLE when inflight=0 and occ=0.
//   - DRAIN -> ACTIVE when en=1.
//  re (combinational, registers only; no m_ready->re path):
//   - re = (state==ACTIVE) & !empty & (occ + inflight < SKID_DEPTH).
//   - re is never asserted while empty=1.
//  inflight:
//   - Register loaded with re each cycle.
//   - When inflight=1, dout is written to skid[wr_ptr] at that edge.
//  Stream side:
//   - m_valid = (occ != 0); m_data = skid[rd_ptr].
//   - Pop on m_valid & m_ready.
//   - m_data must be held stable while m_valid & !m_ready.
//  occ update:
//   - +1 on write, -1 on pop.
//   - Simultaneous write and pop: occ unchanged, both pointers advance.
//   - Pointers wrap modulo SKID_DEPTH.
//   - Overflow is impossible by construction; the bench asserts occ <= SKID_DEPTH.
//  Latency:
//   - empty falls in cycle N with state=ACTIVE and credit free -> re=1 in N.
//   - Byte captured at end of N+1 -> m_valid=1 in N+2.
//  Throughput:
//   - 1 byte/cycle sustained with m_ready=1, FIFO non-empty, SKID_DEPTH>=3.
//   - Backpressure stops re within 1 cycle via credit.
//  Boundary conditions:
//   - en deasserted mid-burst: the in-flight byte is still captured; all buffered bytes are delivered.
//   - rst mid-operation: buffered and in-flight bytes are discarded; FIFO owner resets the FIFO with the same rst.
// CONFIGURATION
//  FIFO_DRAIN_SUM_EN defined:
//   - csum port present: 8-bit sum mod 256 of every accepted byte (m_valid&m_ready).
//   - csum cleared on rst and on the IDLE->ACTIVE transition.
//  FIFO_DRAIN_SUM_EN undefined:
//   - No csum port, no adder; all other behaviour identical.
// STRUCTURE
//  fifo_drain_pkg:
//   - State encoding IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2.
//   - DATA_W default.
//   - clog2 helper for pointer/occ widths.
//  Sub-module drain_skid_buf (SKID_DEPTH entries):
//   - Circular buffer with wr/rd pointers and occ counter.
//   - Ports: push, push_data, pop, head_data, occ.
//  fifo_drain:
//   - Top level holds the FSM, inflight, re/credit logic and the optional checksum.
// TESTING
//  1. Reset, en=1, pre-load FIFO 0x11,0x22,0x33, m_ready=1
//     -> re 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first re.
//  2. 16 bytes 0x00..0x0F, m_ready=0 -> exactly 3 re pulses then re=0, m_valid=1, m_data=0x00 held;
//     raise m_ready -> all 16 bytes in order, no loss or duplicate.
//  3. FIFO empty, en=1 -> re never asserted, m_valid=0, busy=1.
//  4. Drop en during a 10-byte burst with m_ready toggling 1/0
//     -> no re after the drop; every read byte delivered; busy falls once occ=0.
//  5. Assert rst while occ=2 -> next cycle m_valid=0, re=0, busy=0, m_data=0.
//  6. With FIFO_DRAIN_SUM_EN: stream 0xFF,0x02,0x10 -> csum=0x11;
//     en 0->1 via IDLE -> csum=0x00.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - state encoding, width defaults and clog2 helper for fifo_drain
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// rtl/drain_skid_buf.sv - circular skid buffer absorbing the FIFO read latency
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 3,
  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int OCC_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is cleared on reset so the stream data reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign occ       = r_occ;

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - FIFO read-side master feeding a valid/ready byte stream
// Optional running checksum output enabled by defining FIFO_DRAIN_SUM_EN.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SKID_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              empty,
  input  logic [DATA_W-1:0] dout,
  output logic              re,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
`ifdef FIFO_DRAIN_SUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  output logic              busy
);

  localparam int OCC_W = clog2(SKID_DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_inflight;
  logic [OCC_W-1:0]  w_occ;
  logic [OCC_W:0]    w_credit_used;
  logic              w_pop;

  // Credit counts bytes already buffered plus the one still on the FIFO read bus,
  // so re never depends on m_ready combinationally.
  assign w_credit_used = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign re      = (r_state == ST_ACTIVE) && !empty && (w_credit_used < (OCC_W + 1)'(SKID_DEPTH));
  assign m_valid = (w_occ != '0);
  assign w_pop   = m_valid && m_ready;
  assign busy    = (r_state != ST_IDLE);

  drain_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (dout),
    .pop       (w_pop),
    .head_data (m_data),
    .occ       (w_occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= re;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (en) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                                w_state_nxt = ST_ACTIVE;
        else if (!r_inflight && w_occ == '0)   w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef FIFO_DRAIN_SUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE && en)) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum + m_data;
    end
  end

  assign csum = r_csum;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - scoreboard bench for fifo_drain with a queue-based FIFO model
module tb_fifo_drain;

  localparam int SKID = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] dout = 8'h00;
  logic       re;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
`ifdef FIFO_DRAIN_SUM_EN
  logic [7:0] csum;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  byte unsigned fifo_q[$];
  byte unsigned pend_q[$];
  byte unsigned exp_q[$];
  int           re_cyc[$];
  int           acc_cyc[$];
  logic         prev_stall = 1'b0;
  logic [7:0]   held = 8'h00;

  fifo_drain #(.DATA_W(8), .SKID_DEPTH(SKID)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .empty   (empty),
    .dout    (dout),
    .re      (re),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
`ifdef FIFO_DRAIN_SUM_EN
    .csum    (csum),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural 16-deep FIFO: writes become visible the next cycle, reads return a cycle later.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      dout  <= 8'h00;
      empty <= 1'b1;
    end else begin
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      if (re && fifo_q.size() > 0) dout <= fifo_q.pop_front();
      empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: stream order, hold-under-stall, read legality and credit bound.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      re_cyc.delete();
      acc_cyc.delete();
    end else begin
      if (re) begin
        re_cyc.push_back(cyc);
        chk("re_while_empty", int'(empty), 0);
        chk("credit_bound", int'((re_cyc.size() - acc_cyc.size()) <= SKID), 1);
      end
      if (prev_stall) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(held));
      end
      if (m_valid && m_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", m_data);
        end else begin
          chk("stream_data", int'(m_data), int'(exp_q.pop_front()));
        end
      end
      prev_stall = m_valid && !m_ready;
      held       = m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input byte unsigned b);
    pend_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend_q.delete();
    exp_q.delete();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int drop_cyc;
    int n;

    tick(2);
    chk("rst_re", int'(re), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_m_data", int'(m_data), 0);
    rst = 1'b0;

    // 1: three preloaded bytes, back-to-back reads and 2-cycle latency
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    m_ready = 1'b1;
    tick(3);
    en = 1'b1;
    tick(12);
    chk("t1_re_count", re_cyc.size(), 3);
    chk("t1_re_consec1", re_cyc[1], re_cyc[0] + 1);
    chk("t1_re_consec2", re_cyc[2], re_cyc[0] + 2);
    chk("t1_acc_count", acc_cyc.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_acc_cycle", acc_cyc[i], re_cyc[0] + 2 + i);

    // 2: backpressure limits reads to the skid depth, then full in-order release
    en = 1'b0;
    m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    tick(2);
    en = 1'b1;
    tick(12);
    chk("t2_re_count", re_cyc.size(), SKID);
    chk("t2_re_low", int'(re), 0);
    chk("t2_m_valid", int'(m_valid), 1);
    chk("t2_m_data_head", int'(m_data), 0);
    m_ready = 1'b1;
    wait_drained("t2_drain", 200);
    chk("t2_acc_count", acc_cyc.size(), 16);

    // 3: enabled with nothing to read
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    tick(10);
    chk("t3_no_re", re_cyc.size(), 0);
    chk("t3_m_valid", int'(m_valid), 0);
    chk("t3_busy", int'(busy), 1);

    // 4: drop en mid-burst with toggling m_ready
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) push_byte(8'(8'hA0 + i));
    tick(2);
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      m_ready = ~m_ready;
    end
    en = 1'b0;
    drop_cyc = cyc;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      m_ready = ~m_ready;
    end
    chk("t4_no_re_after_drop", int'(re_cyc[re_cyc.size() - 1] <= drop_cyc), 1);
    chk("t4_all_delivered", acc_cyc.size(), re_cyc.size());
    chk("t4_busy_low", int'(busy), 0);
    chk("t4_m_valid_low", int'(m_valid), 0);

    // 5: reset with two bytes buffered
    m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
    tick(2);
    en = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("t5_first_valid", int'(m_valid), 1);
    tick(1);
    rst = 1'b1;
    pend_q.delete();
    exp_q.delete();
    tick(1);
    chk("t5_m_valid", int'(m_valid), 0);
    chk("t5_re", int'(re), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_m_data", int'(m_data), 0);
    rst = 1'b0;
    en = 1'b0;

    // Randomized traffic, enable and backpressure
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 2) == 1 && (fifo_q.size() + pend_q.size()) < 14)
        push_byte(8'($urandom_range(0, 255)));
      m_ready = ($urandom % 4) != 0;
      en      = ($urandom % 16) != 0;
      tick(1);
    end
    en = 1'b1;
    m_ready = 1'b1;
    wait_drained("rand_drain", 300);
    en = 1'b0;
    tick(6);
    chk("rand_busy_low", int'(busy), 0);

`ifdef FIFO_DRAIN_SUM_EN
    // 6: checksum accumulates accepted bytes and clears on IDLE->ACTIVE
    do_reset();
    m_ready = 1'b1;
    push_byte(8'hFF); push_byte(8'h02); push_byte(8'h10);
    tick(2);
    en = 1'b1;
    tick(12);
    chk("t6_csum", int'(csum), 8'h11);
    en = 1'b0;
    tick(6);
    chk("t6_idle", int'(busy), 0);
    en = 1'b1;
    tick(1);
    chk("t6_csum_clear", int'(csum), 0);
    en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
